// File: rtl/lsu_pkg.sv
// Shared types and RV32I funct3 encodings for the load/store unit.
// Optional build macro used by lsu_ctrl: LSU_PERF_CNT_EN.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } lsu_state_e;

    localparam logic [2:0] FUNC3_LB   = 3'b000;
    localparam logic [2:0] FUNC3_LH   = 3'b001;
    localparam logic [2:0] FUNC3_LW   = 3'b010;
    localparam logic [2:0] FUNC3_LBU  = 3'b100;
    localparam logic [2:0] FUNC3_LHU  = 3'b101;
    localparam logic [2:0] FUNC3_SB   = 3'b000;
    localparam logic [2:0] FUNC3_SH   = 3'b001;
    localparam logic [2:0] FUNC3_SW   = 3'b010;
    localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/half lane logic: load extraction, store merge and
// legality/alignment fault detection for incoming requests.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [2:0]  req_func3,
    input  logic        req_is_store,
    output logic        fault,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            FUNC3_LB:  r = {{24{b[7]}}, b};
            FUNC3_LBU: r = {24'd0, b};
            FUNC3_LH:  r = {{16{h[15]}}, h};
            FUNC3_LHU: r = {16'd0, h};
            default:   r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] o, input logic [2:0] f3);
        logic [31:0] r;
        r = w;
        case (f3)
            FUNC3_SB: r[{o, 3'b000} +: 8] = wd[7:0];
            FUNC3_SH: begin
                if (o[1]) r[31:16] = wd[15:0];
                else      r[15:0]  = wd[15:0];
            end
            default:  r = wd;
        endcase
        return r;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic check_fault(input logic [1:0] o, input logic [2:0] f3,
                                         input logic is_store);
        logic legal;
        logic mis;
        if (is_store)
            legal = (f3 == FUNC3_SB) || (f3 == FUNC3_SH) || (f3 == FUNC3_SW);
        else
            legal = (f3 == FUNC3_LB) || (f3 == FUNC3_LH) || (f3 == FUNC3_LW) ||
                    (f3 == FUNC3_LBU) || (f3 == FUNC3_LHU);
        mis = ((f3[1:0] == 2'b01) && o[0]) || ((f3[1:0] == 2'b10) && (o != 2'b00));
        return !legal || mis;
    endfunction

    assign fault      = check_fault(req_off, req_func3, req_is_store);
    assign load_value = extract(rdata, off, func3);
    assign store_word = merge(rdata, wdata, off, func3);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: word-only cache accesses with read-modify-write stores.
// Build macro LSU_PERF_CNT_EN adds load/store/stall performance counters.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_write_data,
    output logic              cache_write_en,
    output logic [2:0]        cache_func3,
    input  logic [DATA_W-1:0] cache_read_data,
    input  logic              cache_hit,
    input  logic              cache_busy,
    output logic [DATA_W-1:0] load_result,
    output logic              done,
    output logic              stall,
    output logic              access_fault
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count,
    output logic [31:0]       stall_cycles
`endif
);

    // Handshake: a request is taken only in IDLE while req_valid and a read or
    // write flag are high; the pipeline holds it until done, stall covers the gap.
    lsu_state_e        state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        func3_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_store_q;
    logic [DATA_W-1:0] load_q;
    logic              fault_q;

    logic              trigger;
    logic              req_fault;
    logic              accept;
    logic              read_done;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] store_word;
    logic              unused_cache_hit;

    assign unused_cache_hit = cache_hit;

    lsu_align u_align (
        .req_off      (req_addr[1:0]),
        .req_func3    (req_func3),
        .req_is_store (mem_write),
        .fault        (req_fault),
        .off          (addr_q[1:0]),
        .func3        (func3_q),
        .rdata        (cache_read_data),
        .wdata        (wdata_q),
        .load_value   (load_value),
        .store_word   (store_word)
    );

    assign trigger   = (state == S_IDLE) && req_valid && (mem_read || mem_write);
    assign accept    = trigger && !req_fault;
    assign read_done = (state == S_RD_WAIT) && !cache_busy;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = S_RD_REQ;
            S_RD_REQ:  state_next = S_RD_WAIT;
            S_RD_WAIT: if (!cache_busy) state_next = is_store_q ? S_WR_REQ : S_DONE;
            S_WR_REQ:  state_next = S_WR_WAIT;
            S_WR_WAIT: if (!cache_busy) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            func3_q    <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            load_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state   <= state_next;
            fault_q <= trigger && req_fault;
            if (accept) begin
                addr_q     <= req_addr;
                func3_q    <= req_func3;
                wdata_q    <= req_wdata;
                is_store_q <= mem_write;
            end
            // Stores reuse wdata_q to hold the merged word for the write phase
            if (read_done) begin
                if (is_store_q) wdata_q <= store_word;
                else            load_q  <= load_value;
            end
        end
    end

    assign cache_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign cache_write_data = wdata_q;
    assign cache_write_en   = (state == S_WR_REQ);
    assign cache_func3      = FUNC3_WORD;
    assign load_result      = load_q;
    assign done             = (state == S_DONE);
    assign access_fault     = fault_q;
    assign stall            = accept || (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                              (state == S_WR_REQ) || (state == S_WR_WAIT);

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count   <= '0;
            store_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (done && !is_store_q) load_count  <= load_count + 32'd1;
            if (done && is_store_q)  store_count <= store_count + 32'd1;
            if (stall)               stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
